// File: rtl/generic_mem_pkg.sv
// Shared types and helpers for the generic_mem controller slice.
// Any file that needs the op encoding or the address-width helper imports this package.
package generic_mem_pkg;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } mem_op_e;

  localparam int DEF_DEPTH = 8;
  localparam int DEF_WIDTH = 32;

  // Floor at 1 so a single-entry structure still gets a real pointer/address bit.
  function automatic int calc_awidth(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int DEF_AWIDTH = calc_awidth(DEF_DEPTH);

  typedef struct packed {
    logic [DEF_AWIDTH-1:0] addr;
    logic [DEF_WIDTH-1:0]  data;
  } rsp_t;

endpackage

// File: rtl/generic_mem.sv
// Simple dual-port word memory: synchronous write, registered read (one-cycle latency).
// A read of an address written at the same edge returns the old contents.
module generic_mem
  import generic_mem_pkg::*;
#(
  parameter int  DEPTH  = 8,
  parameter int  WIDTH  = 32,
  localparam int AWIDTH = calc_awidth(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AWIDTH-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [AWIDTH-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
    if (rd_en) rd_data_q <= mem_q[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/generic_mem_rsp_fifo.sv
// Synchronous circular-buffer FIFO of RSP_DEPTH entries of type T.
// Reports occupancy, empty and full; a push while full or a pop while empty is ignored.
module generic_mem_rsp_fifo
  import generic_mem_pkg::*;
#(
  parameter int  RSP_DEPTH = 4,
  parameter type T         = rsp_t,
  localparam int PW        = calc_awidth(RSP_DEPTH),
  localparam int CW        = $clog2(RSP_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  T              push_data,
  input  logic          pop,
  output T              pop_data,
  output logic [CW-1:0] cnt,
  output logic          empty,
  output logic          full
);

  T              mem_q [RSP_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
    return (ptr == PW'(RSP_DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == CW'(RSP_DEPTH));
  assign cnt      = cnt_q;
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    // Simultaneous push and pop leaves the count where it was.
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Payload storage needs no reset; the pointers decide what is visible.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/generic_mem_ctrl.sv
// Request-side controller for generic_mem: registered issue stage, one-cycle return stage,
// and a credit-guarded response FIFO so every issued read has a guaranteed slot.
module generic_mem_ctrl
  import generic_mem_pkg::*;
#(
  parameter int  DEPTH     = 8,
  parameter int  WIDTH     = 32,
  parameter int  RSP_DEPTH = 4,
  localparam int AWIDTH    = calc_awidth(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [AWIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0]  req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [AWIDTH-1:0] rsp_addr,
  output logic [WIDTH-1:0]  rsp_data,
  output logic              mem_wr_en,
  output logic [AWIDTH-1:0] mem_wr_addr,
  output logic [WIDTH-1:0]  mem_wr_data,
  output logic              mem_rd_en,
  output logic [AWIDTH-1:0] mem_rd_addr,
  input  logic [WIDTH-1:0]  mem_rd_data
);

  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam int SW = CW + 2;

  typedef struct packed {
    logic [AWIDTH-1:0] addr;
    logic [WIDTH-1:0]  data;
  } entry_t;

  logic              rst_n_q;
  logic              mem_wr_en_q, mem_wr_en_d;
  logic [AWIDTH-1:0] mem_wr_addr_q, mem_wr_addr_d;
  logic [WIDTH-1:0]  mem_wr_data_q, mem_wr_data_d;
  logic              mem_rd_en_q, mem_rd_en_d;
  logic [AWIDTH-1:0] mem_rd_addr_q, mem_rd_addr_d;
  logic              s2_rd_q, s2_rd_d;
  logic [AWIDTH-1:0] s2_addr_q, s2_addr_d;

  logic [CW-1:0]     rsp_cnt;
  logic              rsp_empty, rsp_full, rsp_push;
  logic [SW-1:0]     credit_used;
  logic              req_fire;
  mem_op_e           req_op;
  entry_t            push_entry, pop_entry;

  // Reads in S1 and S2 already own a FIFO slot, so ready looks only at registered state.
  assign credit_used = SW'(rsp_cnt) + SW'(mem_rd_en_q) + SW'(s2_rd_q);
  assign req_ready   = rst_n_q && (credit_used < SW'(RSP_DEPTH));
  assign req_fire    = req_valid && req_ready;
  assign req_op      = req_wr ? OP_WR : OP_RD;

  always_comb begin
    mem_wr_en_d   = 1'b0;
    mem_wr_addr_d = mem_wr_addr_q;
    mem_wr_data_d = mem_wr_data_q;
    mem_rd_en_d   = 1'b0;
    mem_rd_addr_d = mem_rd_addr_q;
    s2_rd_d       = mem_rd_en_q;
    s2_addr_d     = mem_rd_addr_q;
    if (req_fire) begin
      if (req_op == OP_WR) begin
        mem_wr_en_d   = 1'b1;
        mem_wr_addr_d = req_addr;
        mem_wr_data_d = req_wdata;
      end else begin
        mem_rd_en_d   = 1'b1;
        mem_rd_addr_d = req_addr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rst_n_q       <= 1'b0;
      mem_wr_en_q   <= 1'b0;
      mem_wr_addr_q <= '0;
      mem_wr_data_q <= '0;
      mem_rd_en_q   <= 1'b0;
      mem_rd_addr_q <= '0;
      s2_rd_q       <= 1'b0;
      s2_addr_q     <= '0;
    end else begin
      rst_n_q       <= 1'b1;
      mem_wr_en_q   <= mem_wr_en_d;
      mem_wr_addr_q <= mem_wr_addr_d;
      mem_wr_data_q <= mem_wr_data_d;
      mem_rd_en_q   <= mem_rd_en_d;
      mem_rd_addr_q <= mem_rd_addr_d;
      s2_rd_q       <= s2_rd_d;
      s2_addr_q     <= s2_addr_d;
    end
  end

  assign push_entry = '{addr: s2_addr_q, data: mem_rd_data};
  assign rsp_push   = s2_rd_q && !rsp_full;

  generic_mem_rsp_fifo #(
    .RSP_DEPTH (RSP_DEPTH),
    .T         (entry_t)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (rsp_push),
    .push_data (push_entry),
    .pop       (rsp_ready),
    .pop_data  (pop_entry),
    .cnt       (rsp_cnt),
    .empty     (rsp_empty),
    .full      (rsp_full)
  );

  assign rsp_valid   = !rsp_empty;
  assign rsp_addr    = pop_entry.addr;
  assign rsp_data    = pop_entry.data;
  assign mem_wr_en   = mem_wr_en_q;
  assign mem_wr_addr = mem_wr_addr_q;
  assign mem_wr_data = mem_wr_data_q;
  assign mem_rd_en   = mem_rd_en_q;
  assign mem_rd_addr = mem_rd_addr_q;

endmodule
